// File: rtl/frame_loader_if.sv
// ---------------------------------------------------------------------------
// frame_loader_if
// Bundles the byte-stream handshake coming from the UART receiver with the
// write port going to the frame RAM.
//   rx_data / rx_valid : byte offered by the receiver
//   rx_ready           : loader will take the byte on this clock edge
//   mem_wr_en          : frame RAM write strobe
//   mem_wr_addr        : frame RAM write address (ADDR_W bits)
//   mem_wr_data        : frame RAM write data (one grayscale pixel)
// Modports:
//   master : environment side (drives the byte stream, observes RAM writes)
//   slave  : loader side (consumes bytes, drives the RAM write port)
// ---------------------------------------------------------------------------
interface frame_loader_if #(
    parameter int ADDR_W = 19
) ();
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );
endinterface

// File: rtl/frame_loader.sv
// ---------------------------------------------------------------------------
// frame_loader
// Writer side of the display frame store. After a start request it waits for
// SYNC_BYTE, then writes one 8-bit pixel per accepted byte into the frame RAM
// in raster order (addr = y*IMG_WIDTH + x, produced by a running counter).
// A gap of TIMEOUT_CYCLES cycles without a byte during the load aborts it and
// raises a sticky error flag.
// Ports:
//   clk_50MHz  : system clock
//   rst        : synchronous, active-high reset
//   start      : single-cycle request to arm a frame load (honoured in IDLE)
//   bus        : byte handshake in, frame RAM write port out (slave modport)
//   busy       : high while waiting for sync or loading pixels
//   frame_done : one-cycle pulse together with the final pixel write
//   error      : sticky timeout flag, cleared by an accepted start or rst
// ---------------------------------------------------------------------------
module frame_loader #(
    parameter int         IMG_WIDTH      = 960,
    parameter int         IMG_HEIGHT     = 540,
    parameter int         ADDR_W         = 19,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 5000000
) (
    input  logic            clk_50MHz,
    input  logic            rst,
    input  logic            start,
    frame_loader_if.slave   bus,
    output logic            busy,
    output logic            frame_done,
    output logic            error
);

    localparam int X_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int Y_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int T_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);
    // The abort fires on the idle edge that would bring the gap count to
    // TIMEOUT_CYCLES, so error rises exactly TIMEOUT_CYCLES cycles after the
    // last accepted byte.
    localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [X_W-1:0]    x_r;
    logic [Y_W-1:0]    y_r;
    logic [ADDR_W-1:0] addr_r;
    logic [T_W-1:0]    tmo_r;

    logic              accept_s;
    logic              last_s;
    logic              wr_s;
    logic              sync_hit_s;
    logic              timeout_s;
    logic              arm_s;

    // Handshake qualifier and end-of-frame position decode.
    always_comb begin
        accept_s = bus.rx_valid && bus.rx_ready;
        last_s   = (x_r == X_LAST) && (y_r == Y_LAST);
    end

    // Next-state logic and per-cycle action strobes.
    always_comb begin
        next_state_s = state_r;
        wr_s         = 1'b0;
        sync_hit_s   = 1'b0;
        timeout_s    = 1'b0;
        arm_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_SYNC;
                    arm_s        = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                // Non-marker bytes are swallowed; no timeout while hunting.
                if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
                    next_state_s = ST_LOAD;
                    sync_hit_s   = 1'b1;
                end else begin
                    next_state_s = ST_SYNC;
                end
            end
            ST_LOAD: begin
                // An accept wins over a timeout landing on the same edge.
                if (accept_s) begin
                    wr_s = 1'b1;
                    if (last_s) begin
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_LOAD;
                    end
                end else if (tmo_r == T_LAST) begin
                    timeout_s    = 1'b1;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered outputs: status flags follow the next state so they line up
    // with the state register; the RAM write lands one cycle after its accept.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            busy            <= 1'b0;
            bus.rx_ready    <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_addr <= {ADDR_W{1'b0}};
            bus.mem_wr_data <= 8'h00;
            frame_done      <= 1'b0;
            error           <= 1'b0;
        end else begin
            busy          <= (next_state_s == ST_SYNC) || (next_state_s == ST_LOAD);
            bus.rx_ready  <= (next_state_s == ST_SYNC) || (next_state_s == ST_LOAD);
            bus.mem_wr_en <= wr_s;
            frame_done    <= wr_s && last_s;
            if (wr_s) begin
                bus.mem_wr_addr <= addr_r;
                bus.mem_wr_data <= bus.rx_data;
            end else begin
                bus.mem_wr_addr <= bus.mem_wr_addr;
                bus.mem_wr_data <= bus.mem_wr_data;
            end
            if (arm_s) begin
                error <= 1'b0;
            end else if (timeout_s) begin
                error <= 1'b1;
            end else begin
                error <= error;
            end
        end
    end

    // Raster position and linear address, advanced together per pixel.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            x_r    <= {X_W{1'b0}};
            y_r    <= {Y_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (sync_hit_s) begin
            x_r    <= {X_W{1'b0}};
            y_r    <= {Y_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else if (wr_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (x_r == X_LAST) begin
                x_r <= {X_W{1'b0}};
                if (y_r == Y_LAST) begin
                    y_r <= {Y_W{1'b0}};
                end else begin
                    y_r <= y_r + Y_W'(1);
                end
            end else begin
                x_r <= x_r + X_W'(1);
                y_r <= y_r;
            end
        end else begin
            x_r    <= x_r;
            y_r    <= y_r;
            addr_r <= addr_r;
        end
    end

    // Inter-byte gap counter, only meaningful while loading.
    always_ff @(posedge clk_50MHz) begin
        if (rst) begin
            tmo_r <= {T_W{1'b0}};
        end else if ((state_r == ST_LOAD) && !accept_s) begin
            tmo_r <= tmo_r + T_W'(1);
        end else begin
            tmo_r <= {T_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_frame_loader
// Randomized scoreboard bench for frame_loader with a small 4x3 frame and a
// 20-cycle timeout. A stimulus process drives inputs and steps a reference
// model of the loader's observable behaviour; expected RAM writes are queued
// and a monitor compares every cycle, #1 after the clock edge.
// ---------------------------------------------------------------------------
module tb_frame_loader;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int AW   = 4;
    localparam int TMO  = 20;
    localparam int NPIX = W * H;

    localparam int M_IDLE = 0;
    localparam int M_SYNC = 1;
    localparam int M_LOAD = 2;
    localparam int M_DONE = 3;

    logic clk_50MHz = 1'b0;
    always #10 clk_50MHz = ~clk_50MHz;

    logic rst;
    logic start;
    logic busy;
    logic frame_done;
    logic error;

    frame_loader_if #(.ADDR_W(AW)) bus ();

    frame_loader #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .ADDR_W        (AW),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .frame_done(frame_done),
        .error     (error)
    );

    typedef struct {
        int  addr;
        int  data;
        bit  done;
    } wr_t;

    wr_t exp_q[$];
    int  checks     = 0;
    int  failures   = 0;
    bit  mon_en     = 1'b0;
    int  m_mode     = M_IDLE;
    int  m_idx      = 0;
    int  m_gap      = 0;
    bit  m_err      = 1'b0;
    int  m_frames   = 0;
    int  dut_frames = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: what the loader must do at the coming clock edge.
    function automatic void model_step();
        wr_t w;
        if (rst) begin
            m_mode = M_IDLE;
            m_err  = 1'b0;
            m_idx  = 0;
            m_gap  = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (start) begin
                    m_mode = M_SYNC;
                    m_err  = 1'b0;
                end
                M_SYNC: if (bus.rx_valid && bus.rx_data == 8'hA5) begin
                    m_mode = M_LOAD;
                    m_idx  = 0;
                    m_gap  = 0;
                end
                M_LOAD: if (bus.rx_valid) begin
                    w.addr = m_idx;
                    w.data = int'(bus.rx_data);
                    w.done = (m_idx == NPIX - 1);
                    exp_q.push_back(w);
                    m_gap = 0;
                    m_idx++;
                    if (m_idx == NPIX) begin
                        m_mode = M_DONE;
                        m_frames++;
                    end
                end else begin
                    m_gap++;
                    if (m_gap == TMO) begin
                        m_mode = M_IDLE;
                        m_err  = 1'b1;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endfunction

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(posedge clk_50MHz);
            #1;
            if (mon_en) begin : mon_body
                bit  exp_busy;
                wr_t e;
                exp_busy = (m_mode == M_SYNC) || (m_mode == M_LOAD);
                chk("busy", 32'(busy), 32'(exp_busy));
                chk("rx_ready", 32'(bus.rx_ready), 32'(exp_busy));
                chk("error", 32'(error), 32'(m_err));
                if (frame_done === 1'b1) dut_frames++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("wr_en", 32'(bus.mem_wr_en), 32'd1);
                    chk("wr_addr", 32'(bus.mem_wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.mem_wr_data), 32'(e.data));
                    chk("frame_done_wr", 32'(frame_done), 32'(e.done));
                end else begin
                    chk("wr_en_quiet", 32'(bus.mem_wr_en), 32'd0);
                    chk("frame_done_quiet", 32'(frame_done), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        model_step();
        @(posedge clk_50MHz);
        #3;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        start        = 1'b0;
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start        = 1'b1;
        bus.rx_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap);
        int gap;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (gap) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            tick();
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] junk_byte();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        // Reset state.
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        chk("rst_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.mem_wr_data), 32'd0);
        rst = 1'b0;

        // Bytes offered without start are refused.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        repeat (3) tick();
        bus.rx_valid = 1'b0;

        // Back-to-back full frame with a leading junk byte; start in DONE.
        pulse_start();
        send(8'h11, 0);
        send(8'hA5, 0);
        for (int i = 0; i < NPIX; i++) send(8'(i), 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        idle(4);

        // Gapped frame, mid-frame 0xA5 pixel, start pulse while loading.
        pulse_start();
        send(junk_byte(), 2);
        send(8'hA5, 2);
        for (int i = 0; i < NPIX; i++) begin
            if (i == 7) pulse_start();
            send((i == 5) ? 8'hA5 : 8'($urandom), 3);
        end
        idle(3);

        // Timeout after five pixels, then start clears error.
        pulse_start();
        send(8'hA5, 0);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1);
        idle(25);
        pulse_start();
        idle(2);

        // Reset held for three cycles in the middle of a load.
        pulse_start();
        send(8'hA5, 0);
        for (int i = 0; i < 6; i++) send(8'($urandom), 0);
        rst          = 1'b1;
        bus.rx_valid = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);
        bus.rx_valid = 1'b1;
        repeat (2) tick();
        idle(2);

        // Randomized frames with junk before the marker.
        repeat (4) begin
            pulse_start();
            repeat ($urandom_range(3, 0)) send(junk_byte(), 2);
            send(8'hA5, 2);
            for (int i = 0; i < NPIX; i++) send(8'($urandom), 4);
            idle(2);
        end

        idle(3);
        chk("frame_count", 32'(dut_frames), 32'(m_frames));
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
